// File: rtl/posit16_encoder_if.sv
// Handshake and field bundle for the 16-bit posit encoder (n=16, es=1).
// The master side presents decoded field sets and accepts posit words;
// the slave side is the encoder itself.
interface posit16_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [4:0]  regi;
  logic        expo;
  logic [11:0] frac;
  logic        allzero;
  logic        allone;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;

  modport master (
    output in_valid, sign, regi, expo, frac, allzero, allone, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, sign, regi, expo, frac, allzero, allone, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/posit16_encoder.sv
// Two-stage pipelined posit16 (es=1) encoder.
// Stage 1 clamps the regime, builds the regime/exponent/fraction bit string,
// extracts the 15-bit magnitude with guard and sticky bits, rounds and
// saturates. Stage 2 applies the NaR/zero specials and the sign
// (two's complement) to form the final word.
// Optional feature macro: POSIT_ENC_RNE_EN. When defined, the magnitude is
// rounded to nearest even; when undefined, it is truncated. Saturation to
// minpos/maxpos, latency and handshake are the same in both builds.
module posit16_encoder (
  input  logic               clk,
  input  logic               rst_n,
  posit16_encoder_if.slave   bus
);

`ifdef POSIT_ENC_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  // Stage 1 holding register.
  logic        s1_valid;
  logic        s1_sign;
  logic        s1_zero;
  logic        s1_nar;
  logic [14:0] s1_mag;

  // Stage 2 holding register, which drives the output port directly.
  logic        s2_valid;
  logic [15:0] s2_word;

  // Handshake terms.
  logic s2_free;
  logic s1_advance;
  logic in_ready_int;
  logic in_fire;

  // Stage 1 datapath terms.
  logic [4:0]  k;
  logic        k_neg;
  logic [4:0]  run;
  logic [31:0] ext;
  logic [31:0] vec;
  logic [14:0] mag_t;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [15:0] mag_sum;
  logic [14:0] mag_sat;

  // Stage 2 datapath term.
  logic [15:0] word_next;

  // Handshake: a stage may load when it is empty or its word leaves this cycle;
  // in_ready depends on out_ready and stage state only, never on in_valid.
  always_comb begin
    s2_free      = !s2_valid || bus.out_ready;
    s1_advance   = s1_valid && s2_free;
    in_ready_int = !s1_valid || s1_advance;
    in_fire      = bus.in_valid && in_ready_int;
  end

  // Regime clamp and run length: k>=0 is (k+1) ones then a 0, k<0 is (-k) zeros then a 1.
  always_comb begin
    k = bus.regi;
    if (bus.regi == 5'b01111) begin
      k = 5'b01110;
    end else if (bus.regi == 5'b10000) begin
      k = 5'b10001;
    end
    k_neg = k[4];
    if (k_neg) begin
      run = 5'd0 - k;
    end else begin
      run = k + 5'd1;
    end
  end

  // Bit string build: the terminator bit, exponent and fraction are shifted
  // right by the run length, filling with the run polarity from the top.
  always_comb begin
    ext = {k_neg, bus.expo, bus.frac, 18'd0};
    if (k_neg) begin
      vec = ext >> run;
    end else begin
      vec = ~((~ext) >> run);
    end
    mag_t  = vec[31:17];
    guard  = vec[16];
    sticky = |vec[15:0];
  end

  // Rounding (nearest-even or truncation) followed by maxpos/minpos saturation.
  always_comb begin
    round_up = RNE_EN & guard & (mag_t[0] | sticky);
    mag_sum  = {1'b0, mag_t} + {15'd0, round_up};
    if (mag_sum[15]) begin
      mag_sat = 15'h7FFF;
    end else if (mag_sum[14:0] == 15'd0) begin
      mag_sat = 15'h0001;
    end else begin
      mag_sat = mag_sum[14:0];
    end
  end

  // Stage 1 register: captures a new field set on every input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_mag   <= 15'd0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sign  <= bus.sign;
        s1_zero  <= bus.allzero;
        s1_nar   <= bus.allone;
        s1_mag   <= mag_sat;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Final word: NaR beats zero, then the sign selects two's complement.
  always_comb begin
    word_next = {1'b0, s1_mag};
    if (s1_nar) begin
      word_next = 16'h8000;
    end else if (s1_zero) begin
      word_next = 16'h0000;
    end else if (s1_sign) begin
      word_next = (~{1'b0, s1_mag}) + 16'd1;
    end
  end

  // Stage 2 register: loads from stage 1 or empties when the word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_word  <= 16'h0000;
    end else begin
      if (s1_advance) begin
        s2_valid <= 1'b1;
        s2_word  <= word_next;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_word;

endmodule

// File: tb/tb_posit16_encoder.sv
// Directed self-checking bench for posit16_encoder.
module tb_posit16_encoder;

  logic clk = 1'b0;
  logic rst_n;

  posit16_encoder_if bus ();

  posit16_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic        s;
    logic [4:0]  r;
    logic        e;
    logic [11:0] f;
    logic        z;
    logic        n;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(string name, logic s, logic [4:0] r, logic e,
                              logic [11:0] f, logic z, logic n, logic [15:0] exp);
    vec_t v;
    v.name = name;
    v.s    = s;
    v.r    = r;
    v.e    = e;
    v.f    = f;
    v.z    = z;
    v.n    = n;
    v.exp  = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.sign    = v.s;
    bus.regi    = v.r;
    bus.expo    = v.e;
    bus.frac    = v.f;
    bus.allzero = v.z;
    bus.allone  = v.n;
  endtask

  // Sends one word with out_ready high; returns the word seen and the number
  // of rising edges from the transfer edge until out_valid was observed.
  task automatic run_single(input vec_t v, output logic [15:0] got, output int lat);
    @(negedge clk);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = bus.out;
  endtask

  task automatic drain();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk("idle", 1'b0, 5'd0, 1'b0, 12'd0, 1'b0, 1'b0, 16'h0));
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.out !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", bus.out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_exact();
    vec_t v[6];
    logic [15:0] got;
    int lat;
    v[0] = mk("exact_one",     1'b0, 5'd0,     1'b0, 12'h000, 1'b0, 1'b0, 16'h4000);
    v[1] = mk("exact_neg_one", 1'b1, 5'd0,     1'b0, 12'h000, 1'b0, 1'b0, 16'hC000);
    v[2] = mk("exact_k1",      1'b0, 5'd1,     1'b1, 12'h800, 1'b0, 1'b0, 16'h6C00);
    v[3] = mk("exact_km1",     1'b0, 5'b11111, 1'b1, 12'h000, 1'b0, 1'b0, 16'h3000);
    v[4] = mk("exact_km2_neg", 1'b1, 5'b11110, 1'b0, 12'h000, 1'b0, 1'b0, 16'hF000);
    v[5] = mk("exact_k0_frac", 1'b0, 5'd0,     1'b1, 12'h800, 1'b0, 1'b0, 16'h5800);
    for (int i = 0; i < 6; i++) begin
      run_single(v[i], got, lat);
      checks++;
      if (got !== v[i].exp) $display("FAIL %s: got %h expected %h", v[i].name, got, v[i].exp);
      else passed++;
      checks++;
      if (lat != 2) $display("FAIL %s_latency: got %0d expected 2", v[i].name, lat);
      else passed++;
    end
  endtask

  // With k=0 the 12 fraction bits fit exactly; larger k pushes fraction bits
  // into guard/sticky, so the rounding vectors use k=1 and k=2.
  task automatic test_rounding();
    vec_t v[6];
    logic [15:0] got;
    int lat;
`ifdef POSIT_ENC_RNE_EN
    v[0] = mk("rnd_tie_even",  1'b0, 5'd1, 1'b0, 12'h001, 1'b0, 1'b0, 16'h6000);
    v[1] = mk("rnd_tie_odd",   1'b0, 5'd1, 1'b0, 12'h003, 1'b0, 1'b0, 16'h6002);
    v[2] = mk("rnd_sticky",    1'b0, 5'd2, 1'b0, 12'h003, 1'b0, 1'b0, 16'h7001);
    v[3] = mk("rnd_tie_k2",    1'b0, 5'd2, 1'b0, 12'h006, 1'b0, 1'b0, 16'h7002);
    v[4] = mk("rnd_neg",       1'b1, 5'd1, 1'b0, 12'h003, 1'b0, 1'b0, 16'h9FFE);
    v[5] = mk("rnd_carry",     1'b0, 5'd2, 1'b0, 12'hFFF, 1'b0, 1'b0, 16'h7400);
`else
    v[0] = mk("rnd_tie_even",  1'b0, 5'd1, 1'b0, 12'h001, 1'b0, 1'b0, 16'h6000);
    v[1] = mk("rnd_tie_odd",   1'b0, 5'd1, 1'b0, 12'h003, 1'b0, 1'b0, 16'h6001);
    v[2] = mk("rnd_sticky",    1'b0, 5'd2, 1'b0, 12'h003, 1'b0, 1'b0, 16'h7000);
    v[3] = mk("rnd_tie_k2",    1'b0, 5'd2, 1'b0, 12'h006, 1'b0, 1'b0, 16'h7001);
    v[4] = mk("rnd_neg",       1'b1, 5'd1, 1'b0, 12'h003, 1'b0, 1'b0, 16'h9FFF);
    v[5] = mk("rnd_carry",     1'b0, 5'd2, 1'b0, 12'hFFF, 1'b0, 1'b0, 16'h73FF);
`endif
    for (int i = 0; i < 6; i++) begin
      run_single(v[i], got, lat);
      checks++;
      if (got !== v[i].exp) $display("FAIL %s: got %h expected %h", v[i].name, got, v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    vec_t v[7];
    logic [15:0] got;
    int lat;
    v[0] = mk("sat_maxpos",      1'b0, 5'd14,    1'b1, 12'hFFF, 1'b0, 1'b0, 16'h7FFF);
    v[1] = mk("sat_maxpos_neg",  1'b1, 5'd14,    1'b0, 12'h000, 1'b0, 1'b0, 16'h8001);
    v[2] = mk("sat_minpos",      1'b0, 5'b10001, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0001);
    v[3] = mk("sat_minpos_neg",  1'b1, 5'b10001, 1'b0, 12'h000, 1'b0, 1'b0, 16'hFFFF);
    v[4] = mk("sat_minpos_frac", 1'b0, 5'b10001, 1'b1, 12'h800, 1'b0, 1'b0, 16'h0001);
    v[5] = mk("sat_clamp_15",    1'b0, 5'b01111, 1'b0, 12'h000, 1'b0, 1'b0, 16'h7FFF);
    v[6] = mk("sat_clamp_m16",   1'b0, 5'b10000, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0001);
    for (int i = 0; i < 7; i++) begin
      run_single(v[i], got, lat);
      checks++;
      if (got !== v[i].exp) $display("FAIL %s: got %h expected %h", v[i].name, got, v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_specials();
    vec_t v[4];
    logic [15:0] got;
    int lat;
    v[0] = mk("spec_nar",       1'b0, 5'd3,     1'b1, 12'h5A5, 1'b0, 1'b1, 16'h8000);
    v[1] = mk("spec_nar_neg",   1'b1, 5'b11100, 1'b0, 12'h123, 1'b0, 1'b1, 16'h8000);
    v[2] = mk("spec_zero",      1'b1, 5'd2,     1'b1, 12'hABC, 1'b1, 1'b0, 16'h0000);
    v[3] = mk("spec_both",      1'b0, 5'd0,     1'b0, 12'h000, 1'b1, 1'b1, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      run_single(v[i], got, lat);
      checks++;
      if (got !== v[i].exp) $display("FAIL %s: got %h expected %h", v[i].name, got, v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[6];
    logic [15:0] got[6];
    int sent, rcv, stalls, ncyc;
    logic in_f;
    v[0] = mk("b2b0", 1'b0, 5'd0,     1'b0, 12'h000, 1'b0, 1'b0, 16'h4000);
    v[1] = mk("b2b1", 1'b0, 5'b11101, 1'b1, 12'h000, 1'b0, 1'b0, 16'h0C00);
    v[2] = mk("b2b2", 1'b1, 5'b11110, 1'b0, 12'h000, 1'b0, 1'b0, 16'hF000);
    v[3] = mk("b2b3", 1'b0, 5'd1,     1'b1, 12'h800, 1'b0, 1'b0, 16'h6C00);
    v[4] = mk("b2b4", 1'b0, 5'd0,     1'b0, 12'h000, 1'b0, 1'b1, 16'h8000);
    v[5] = mk("b2b5", 1'b1, 5'd0,     1'b0, 12'h000, 1'b0, 1'b0, 16'hC000);
    sent = 0; rcv = 0; stalls = 0; ncyc = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (sent < 6) begin
        drive(v[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      in_f = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (bus.out_valid === 1'b1) begin
        got[rcv] = bus.out;
        rcv++;
      end
      ncyc++;
      @(posedge clk);
      if (in_f) sent++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rcv != 6) $display("FAIL b2b_count: got %0d words expected 6", rcv);
    else passed++;
    checks++;
    if (stalls != 0) $display("FAIL b2b_stalls: got %0d stalls expected 0", stalls);
    else passed++;
    checks++;
    if (ncyc != 8) $display("FAIL b2b_cycles: got %0d cycles expected 8", ncyc);
    else passed++;
    for (int i = 0; i < rcv; i++) begin
      checks++;
      if (got[i] !== v[i].exp) $display("FAIL %s: got %h expected %h", v[i].name, got[i], v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    vec_t v[4];
    logic [15:0] got[4];
    int sent, rcv;
    logic in_f;
    v[0] = mk("bp0", 1'b0, 5'd0,  1'b0, 12'h000, 1'b0, 1'b0, 16'h4000);
    v[1] = mk("bp1", 1'b1, 5'd0,  1'b0, 12'h000, 1'b0, 1'b0, 16'hC000);
    v[2] = mk("bp2", 1'b0, 5'd1,  1'b1, 12'h800, 1'b0, 1'b0, 16'h6C00);
    v[3] = mk("bp3", 1'b0, 5'd14, 1'b0, 12'h000, 1'b0, 1'b0, 16'h7FFF);
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 1 && cyc <= 4);
      if (sent < 4) begin
        drive(v[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b expected 0", cyc, bus.in_ready);
        else passed++;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'h4000)
          $display("FAIL bp_hold_c%0d: got valid=%b out=%h expected valid=1 out=4000", cyc, bus.out_valid, bus.out);
        else passed++;
      end
      if (cyc == 5) begin
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_shift_accept: got %b expected 1", bus.in_ready);
        else passed++;
      end
      in_f = bus.in_valid && bus.in_ready;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got[rcv] = bus.out;
        rcv++;
      end
      @(posedge clk);
      if (in_f) sent++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rcv != 4) $display("FAIL bp_count: got %0d words expected 4", rcv);
    else passed++;
    for (int i = 0; i < rcv; i++) begin
      checks++;
      if (got[i] !== v[i].exp) $display("FAIL %s: got %h expected %h", v[i].name, got[i], v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] got;
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(mk("rm0", 1'b0, 5'd0, 1'b0, 12'h000, 1'b0, 1'b0, 16'h4000));
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(mk("rm1", 1'b1, 5'd0, 1'b0, 12'h000, 1'b0, 1'b0, 16'hC000));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL rm_inflight: got out_valid=%b expected 1", bus.out_valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b expected 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.out !== 16'h0000) $display("FAIL rm_out: got %h expected 0000", bus.out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run_single(mk("rm_new", 1'b0, 5'd1, 1'b1, 12'h800, 1'b0, 1'b0, 16'h6C00), got, lat);
    checks++;
    if (got !== 16'h6C00) $display("FAIL rm_new_word: got %h expected 6C00", got);
    else passed++;
    checks++;
    if (lat != 2) $display("FAIL rm_new_latency: got %0d expected 2", lat);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rm_no_stale: got out_valid=%b expected 0", bus.out_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_exact();
    drain();
    test_rounding();
    drain();
    test_saturation();
    drain();
    test_specials();
    drain();
    test_back_to_back();
    drain();
    test_backpressure();
    drain();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
